// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga memory stage.
// The requester-ID width helper is used by the memory request arbiter.
package tartaruga_pkg;

   localparam int MEM_ARB_MAX_REQ = 8;

   typedef logic [2:0] mem_arb_id_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] data;
   } mem_req_t;

   function automatic int mem_arb_id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Requester-ID FIFO for in-order outstanding memory transactions.
// Full and empty come from the occupancy count; the pointers wrap modulo DEPTH.
module mem_arb_id_fifo #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 2
) (
   input  logic                         clk_i,
   input  logic                         rstn_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [WIDTH-1:0]             data_i,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o,
   output logic [WIDTH-1:0]             head_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_push, do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= data_i;
            wptr_q        <= ptr_inc(wptr_q);
         end
         if (do_pop) rptr_q <= ptr_inc(rptr_q);
         if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
      end
   end

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/mem_req_arbiter.sv
// N-requester arbiter in front of the single dmem port, fixed-priority or round-robin,
// with in-order response routing through a requester-ID FIFO.
module mem_req_arbiter
   import tartaruga_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int LINE_W    = 128,
   parameter int MAX_OUTST = 2,
   parameter int ARB_RR    = 0
) (
   input  logic                              clk_i,
   input  logic                              rstn_i,
   input  logic [NUM_REQ-1:0]                req_valid_i,
   output logic [NUM_REQ-1:0]                req_ready_o,
   input  logic [NUM_REQ*ADDR_W-1:0]         req_addr_i,
   input  logic [NUM_REQ-1:0]                req_we_i,
   input  logic [NUM_REQ*DATA_W-1:0]         req_data_i,
   output logic [NUM_REQ-1:0]                rsp_valid_o,
   input  logic [NUM_REQ-1:0]                rsp_ready_i,
   output logic [LINE_W-1:0]                 rsp_data_o,
   output logic [ADDR_W-1:0]                 rsp_addr_o,
   output logic                              mem_req_valid_o,
   input  logic                              mem_req_ready_i,
   output logic [ADDR_W-1:0]                 mem_addr_o,
   output logic                              mem_we_o,
   output logic [DATA_W-1:0]                 mem_data_wr_o,
   input  logic                              mem_rsp_valid_i,
   output logic                              mem_rsp_ready_o,
   input  logic [ADDR_W-1:0]                 mem_rsp_addr_i,
   input  logic [LINE_W-1:0]                 mem_data_line_i,
   output logic [$clog2(MAX_OUTST+1)-1:0]    outst_cnt_o,
   output logic                              busy_o,
   output logic                              err_o
);

   localparam int ID_W  = mem_arb_id_w(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   // Handshakes: a transfer happens on a cycle where valid && ready are both high; a
   // valid source holds its payload stable until that cycle, and ready may depend on valid.
   logic [ID_W-1:0]  rr_ptr_q, lock_id_q, arb_id, gnt_id, head_id, cand;
   logic [ID_W:0]    rot_sum;
   logic             lock_q, arb_hit, gnt_valid, rsp_ready_sel, err_q;
   logic             fifo_full, fifo_empty, push, pop;
   logic [CNT_W-1:0] fifo_cnt;

   always_comb begin
      arb_hit = 1'b0;
      arb_id  = '0;
      rot_sum = '0;
      cand    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rot_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (rot_sum >= (ID_W+1)'(NUM_REQ)) rot_sum = rot_sum - (ID_W+1)'(NUM_REQ);
         cand = (ARB_RR != 0) ? rot_sum[ID_W-1:0] : ID_W'(i);
         if (!arb_hit && req_valid_i[cand]) begin
            arb_hit = 1'b1;
            arb_id  = cand;
         end
      end
   end

   // A stalled grant is frozen so the downstream payload cannot change under backpressure.
   assign gnt_id    = lock_q ? lock_id_q : arb_id;
   assign gnt_valid = lock_q ? req_valid_i[lock_id_q] : arb_hit;

   assign mem_req_valid_o = gnt_valid && !fifo_full;
   assign push            = mem_req_valid_o && mem_req_ready_i;
   assign mem_addr_o      = mem_req_valid_o ? req_addr_i[gnt_id*ADDR_W +: ADDR_W] : '0;
   assign mem_data_wr_o   = mem_req_valid_o ? req_data_i[gnt_id*DATA_W +: DATA_W] : '0;
   assign mem_we_o        = mem_req_valid_o && req_we_i[gnt_id];

   always_comb begin
      req_ready_o = '0;
      if (push) req_ready_o[gnt_id] = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         lock_q    <= 1'b0;
         lock_id_q <= '0;
         rr_ptr_q  <= '0;
         err_q     <= 1'b0;
      end else begin
         if (push) begin
            lock_q <= 1'b0;
         end else if (mem_req_valid_o) begin
            lock_q    <= 1'b1;
            lock_id_q <= gnt_id;
         end
         if (push && (ARB_RR != 0))
            rr_ptr_q <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
         if (mem_rsp_valid_i && fifo_empty) err_q <= 1'b1;
      end
   end

   always_comb begin
      rsp_valid_o   = '0;
      rsp_ready_sel = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (head_id == ID_W'(k)) begin
            rsp_valid_o[k] = mem_rsp_valid_i && !fifo_empty;
            rsp_ready_sel  = rsp_ready_i[k];
         end
      end
   end

   // Responses with nothing outstanding are drained and flagged rather than routed.
   assign mem_rsp_ready_o = fifo_empty ? mem_rsp_valid_i : rsp_ready_sel;
   assign pop             = mem_rsp_valid_i && !fifo_empty && rsp_ready_sel;
   assign rsp_data_o      = mem_data_line_i;
   assign rsp_addr_o      = mem_rsp_addr_i;

   mem_arb_id_fifo #(
      .WIDTH (ID_W),
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (gnt_id),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_cnt),
      .head_o  (head_id)
   );

   assign outst_cnt_o = fifo_cnt;
   assign busy_o      = (fifo_cnt != '0) || mem_req_valid_o;
   assign err_o       = err_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a 2-client fixed-priority instance (depth 2)
// and a 4-client round-robin instance (depth 8) driven from one linear sequence.
module tb_mem_req_arbiter;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   logic rstn_i;

   int errors = 0;
   int checks = 0;

   // instance a: NUM_REQ=2, MAX_OUTST=2, fixed priority
   logic [1:0]   a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready;
   logic [63:0]  a_req_addr, a_req_data;
   logic [127:0] a_rsp_data, a_mem_line;
   logic [31:0]  a_rsp_addr, a_mem_addr, a_mem_data_wr, a_mem_rsp_addr;
   logic         a_mem_req_valid, a_mem_req_ready, a_mem_we, a_mem_rsp_valid, a_mem_rsp_ready;
   logic         a_busy, a_err;
   logic [1:0]   a_cnt;

   // instance b: NUM_REQ=4, MAX_OUTST=8, round robin
   logic [3:0]   b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready;
   logic [127:0] b_req_addr, b_req_data;
   logic [127:0] b_rsp_data, b_mem_line;
   logic [31:0]  b_rsp_addr, b_mem_addr, b_mem_data_wr, b_mem_rsp_addr;
   logic         b_mem_req_valid, b_mem_req_ready, b_mem_we, b_mem_rsp_valid, b_mem_rsp_ready;
   logic         b_busy, b_err;
   logic [3:0]   b_cnt;

   logic [1:0]   exp_q[$];
   logic [1:0]   e;

   mem_req_arbiter #(
      .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .LINE_W(128), .MAX_OUTST(2), .ARB_RR(0)
   ) dut_a (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req_valid_i(a_req_valid), .req_ready_o(a_req_ready), .req_addr_i(a_req_addr),
      .req_we_i(a_req_we), .req_data_i(a_req_data),
      .rsp_valid_o(a_rsp_valid), .rsp_ready_i(a_rsp_ready), .rsp_data_o(a_rsp_data),
      .rsp_addr_o(a_rsp_addr),
      .mem_req_valid_o(a_mem_req_valid), .mem_req_ready_i(a_mem_req_ready),
      .mem_addr_o(a_mem_addr), .mem_we_o(a_mem_we), .mem_data_wr_o(a_mem_data_wr),
      .mem_rsp_valid_i(a_mem_rsp_valid), .mem_rsp_ready_o(a_mem_rsp_ready),
      .mem_rsp_addr_i(a_mem_rsp_addr), .mem_data_line_i(a_mem_line),
      .outst_cnt_o(a_cnt), .busy_o(a_busy), .err_o(a_err)
   );

   mem_req_arbiter #(
      .NUM_REQ(4), .ADDR_W(32), .DATA_W(32), .LINE_W(128), .MAX_OUTST(8), .ARB_RR(1)
   ) dut_b (
      .clk_i(clk_i), .rstn_i(rstn_i),
      .req_valid_i(b_req_valid), .req_ready_o(b_req_ready), .req_addr_i(b_req_addr),
      .req_we_i(b_req_we), .req_data_i(b_req_data),
      .rsp_valid_o(b_rsp_valid), .rsp_ready_i(b_rsp_ready), .rsp_data_o(b_rsp_data),
      .rsp_addr_o(b_rsp_addr),
      .mem_req_valid_o(b_mem_req_valid), .mem_req_ready_i(b_mem_req_ready),
      .mem_addr_o(b_mem_addr), .mem_we_o(b_mem_we), .mem_data_wr_o(b_mem_data_wr),
      .mem_rsp_valid_i(b_mem_rsp_valid), .mem_rsp_ready_o(b_mem_rsp_ready),
      .mem_rsp_addr_i(b_mem_rsp_addr), .mem_data_line_i(b_mem_line),
      .outst_cnt_o(b_cnt), .busy_o(b_busy), .err_o(b_err)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // clock/reset
      rstn_i = 1'b0;
      a_req_valid = '0; a_req_we = '0; a_rsp_ready = '0; a_req_addr = '0; a_req_data = '0;
      a_mem_req_ready = 1'b0; a_mem_rsp_valid = 1'b0; a_mem_rsp_addr = '0; a_mem_line = '0;
      b_req_valid = '0; b_req_we = '0; b_rsp_ready = '0; b_req_addr = '0; b_req_data = '0;
      b_mem_req_ready = 1'b0; b_mem_rsp_valid = 1'b0; b_mem_rsp_addr = '0; b_mem_line = '0;
      #12;
      chk("rst_a_req_ready", a_req_ready, 0);
      chk("rst_a_mem_req_valid", a_mem_req_valid, 0);
      chk("rst_a_rsp_valid", a_rsp_valid, 0);
      chk("rst_a_mem_rsp_ready", a_mem_rsp_ready, 0);
      chk("rst_a_cnt", a_cnt, 0);
      chk("rst_a_busy", a_busy, 0);
      chk("rst_a_err", a_err, 0);
      chk("rst_b_cnt", b_cnt, 0);
      rstn_i = 1'b1;
      tick();

      // fixed priority contention
      a_req_addr = {32'h200, 32'h100};
      a_req_data = {32'h22, 32'h11};
      a_req_we = 2'b01;
      a_req_valid = 2'b11;
      a_mem_req_ready = 1'b1;
      #1;
      chk("fp_valid", a_mem_req_valid, 1);
      chk("fp_addr0", a_mem_addr, 32'h100);
      chk("fp_we0", a_mem_we, 1);
      chk("fp_data0", a_mem_data_wr, 32'h11);
      chk("fp_ready0", a_req_ready, 2'b01);
      tick();
      a_req_valid = 2'b10;
      #1;
      chk("fp_addr1", a_mem_addr, 32'h200);
      chk("fp_we1", a_mem_we, 0);
      chk("fp_data1", a_mem_data_wr, 32'h22);
      chk("fp_ready1", a_req_ready, 2'b10);
      chk("fp_cnt1", a_cnt, 1);
      tick();
      a_req_valid = 2'b00;
      #1;
      chk("fp_cnt2", a_cnt, 2);
      chk("fp_idle_valid", a_mem_req_valid, 0);
      chk("fp_busy", a_busy, 1);
      a_mem_rsp_valid = 1'b1;
      a_mem_line = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
      a_mem_rsp_addr = 32'h100;
      a_rsp_ready = 2'b11;
      #1;
      chk("fp_rsp0_valid", a_rsp_valid, 2'b01);
      chk("fp_rsp0_data", a_rsp_data, 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA);
      chk("fp_rsp0_addr", a_rsp_addr, 32'h100);
      chk("fp_rsp0_ready", a_mem_rsp_ready, 1);
      tick();
      a_mem_line = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
      a_mem_rsp_addr = 32'h200;
      #1;
      chk("fp_rsp1_valid", a_rsp_valid, 2'b10);
      chk("fp_rsp1_data", a_rsp_data, 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB);
      chk("fp_rsp1_addr", a_rsp_addr, 32'h200);
      tick();
      a_mem_rsp_valid = 1'b0;
      #1;
      chk("fp_drained_cnt", a_cnt, 0);
      chk("fp_drained_busy", a_busy, 0);
      chk("fp_no_err", a_err, 0);

      // lock under backpressure
      a_mem_req_ready = 1'b0;
      a_req_addr = {32'h300, 32'h400};
      a_req_we = 2'b00;
      a_req_valid = 2'b10;
      #1;
      chk("lock_valid", a_mem_req_valid, 1);
      chk("lock_addr0", a_mem_addr, 32'h300);
      chk("lock_ready0", a_req_ready, 2'b00);
      tick();
      a_req_valid = 2'b11;
      #1;
      chk("lock_addr1", a_mem_addr, 32'h300);
      chk("lock_ready1", a_req_ready, 2'b00);
      tick();
      #1;
      chk("lock_addr2", a_mem_addr, 32'h300);
      tick();
      a_mem_req_ready = 1'b1;
      #1;
      chk("lock_release_ready", a_req_ready, 2'b10);
      chk("lock_release_addr", a_mem_addr, 32'h300);
      tick();
      a_req_valid = 2'b01;
      #1;
      chk("after_lock_ready", a_req_ready, 2'b01);
      chk("after_lock_addr", a_mem_addr, 32'h400);
      chk("after_lock_cnt", a_cnt, 1);
      tick();

      // outstanding limit
      a_req_addr = {32'h500, 32'h400};
      a_req_valid = 2'b10;
      #1;
      chk("full_cnt", a_cnt, 2);
      chk("full_no_valid", a_mem_req_valid, 0);
      chk("full_no_ready", a_req_ready, 2'b00);
      a_mem_rsp_valid = 1'b1;
      a_mem_line = 128'hCCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC_CCCC;
      #1;
      chk("full_rsp_head1", a_rsp_valid, 2'b10);
      chk("full_pop_no_push", a_mem_req_valid, 0);
      chk("full_pop_no_ready", a_req_ready, 2'b00);
      tick();
      a_mem_rsp_valid = 1'b0;
      #1;
      chk("released_cnt", a_cnt, 1);
      chk("released_valid", a_mem_req_valid, 1);
      chk("released_ready", a_req_ready, 2'b10);
      chk("released_addr", a_mem_addr, 32'h500);
      tick();
      a_req_valid = 2'b00;
      #1;
      chk("refill_cnt", a_cnt, 2);
      a_mem_rsp_valid = 1'b1;
      #1;
      chk("order_head0", a_rsp_valid, 2'b01);
      tick();
      #1;
      chk("order_head1", a_rsp_valid, 2'b10);
      tick();
      a_mem_rsp_valid = 1'b0;
      #1;
      chk("order_drained", a_cnt, 0);

      // round-robin fairness
      b_req_addr = {32'h1030, 32'h1020, 32'h1010, 32'h1000};
      b_mem_req_ready = 1'b1;
      b_req_valid = 4'hF;
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
      exp_q.push_back(2'd0);
      for (int n = 0; n < 5; n++) begin
         #1;
         e = exp_q.pop_front();
         chk("rr_grant", b_req_ready, 4'b0001 << e);
         chk("rr_addr", b_mem_addr, 32'h1000 + 32'(e) * 32'h10);
         tick();
      end
      b_req_valid = 4'b1001;
      #1;
      chk("rr_skip_ready", b_req_ready, 4'b1000);
      chk("rr_skip_addr", b_mem_addr, 32'h1030);
      tick();
      b_req_valid = 4'b0000;
      #1;
      chk("rr_cnt", b_cnt, 6);

      // response routing and backpressure, heads 0,1,2,3,0,3
      b_rsp_ready = 4'hF;
      b_mem_rsp_valid = 1'b1;
      b_mem_line = 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD;
      #1;
      chk("b_rsp_head0", b_rsp_valid, 4'b0001);
      chk("b_rsp_data", b_rsp_data, 128'hDDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD_DDDD);
      tick();
      #1;
      chk("b_rsp_head1", b_rsp_valid, 4'b0010);
      tick();
      b_rsp_ready = 4'b1011;
      #1;
      chk("bp_valid", b_rsp_valid, 4'b0100);
      chk("bp_mem_ready", b_mem_rsp_ready, 0);
      tick();
      #1;
      chk("bp_no_pop_cnt", b_cnt, 4);
      chk("bp_head_held", b_rsp_valid, 4'b0100);
      b_rsp_ready = 4'hF;
      #1;
      chk("bp_release_ready", b_mem_rsp_ready, 1);
      tick();
      #1;
      chk("bp_pop_cnt", b_cnt, 3);
      chk("b_rsp_head3", b_rsp_valid, 4'b1000);
      tick();
      #1;
      chk("b_rsp_head0b", b_rsp_valid, 4'b0001);
      tick();
      #1;
      chk("b_rsp_head3b", b_rsp_valid, 4'b1000);
      tick();
      b_mem_rsp_valid = 1'b0;
      #1;
      chk("b_drained_cnt", b_cnt, 0);
      chk("b_no_err", b_err, 0);

      // protocol error: response with nothing outstanding
      a_mem_rsp_valid = 1'b1;
      #1;
      chk("err_no_rsp_valid", a_rsp_valid, 2'b00);
      chk("err_drain_ready", a_mem_rsp_ready, 1);
      chk("err_not_yet", a_err, 0);
      tick();
      a_mem_rsp_valid = 1'b0;
      #1;
      chk("err_set", a_err, 1);
      tick();
      #1;
      chk("err_sticky", a_err, 1);

      // reset mid-transaction
      a_req_addr = {32'h700, 32'h600};
      a_req_valid = 2'b01;
      a_mem_req_ready = 1'b1;
      tick();
      a_req_valid = 2'b10;
      a_mem_req_ready = 1'b0;
      #1;
      chk("pre_rst_cnt", a_cnt, 1);
      tick();
      rstn_i = 1'b0;
      a_req_valid = 2'b00;
      #1;
      chk("mid_rst_cnt", a_cnt, 0);
      chk("mid_rst_busy", a_busy, 0);
      chk("mid_rst_err", a_err, 0);
      chk("mid_rst_mem_valid", a_mem_req_valid, 0);
      chk("mid_rst_req_ready", a_req_ready, 0);
      chk("mid_rst_rsp_valid", a_rsp_valid, 0);
      chk("mid_rst_mem_rsp_ready", a_mem_rsp_ready, 0);
      tick();
      rstn_i = 1'b1;
      tick();
      a_mem_rsp_valid = 1'b1;
      a_mem_line = 128'hEEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE_EEEE;
      #1;
      chk("stale_no_rsp_valid", a_rsp_valid, 2'b00);
      tick();
      a_mem_rsp_valid = 1'b0;
      #1;
      chk("stale_err", a_err, 1);
      chk("stale_cnt", a_cnt, 0);
      a_req_valid = 2'b01;
      a_mem_req_ready = 1'b1;
      #1;
      chk("post_rst_unlocked", a_req_ready, 2'b01);
      chk("post_rst_addr", a_mem_addr, 32'h600);
      tick();
      a_req_valid = 2'b00;
      #1;
      chk("post_rst_cnt", a_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
